// File: rtl/bp_common_pkg.sv
// Shared front-end command definitions for the back end.
// The command struct depends on address widths chosen by each user, so it is
// provided as a declaration macro rather than a fixed package type.
`ifndef BP_COMMON_PKG_SV
`define BP_COMMON_PKG_SV

`define DECLARE_BP_BE_FE_CMD_S(vaddr_w, ptag_w) \
    typedef struct packed { \
        bp_fe_command_queue_opcodes_e opcode; \
        logic [(vaddr_w)-1:0]         vaddr; \
        logic [(ptag_w)-1:0]          ptag; \
    } bp_be_fe_cmd_s

package bp_common_pkg;

    // Front-end command opcodes carried in the top bits of each FE command
    typedef enum logic [2:0] {
        e_op_pc_redirect        = 3'd0,
        e_op_icache_fill_resume = 3'd1,
        e_op_icache_fence       = 3'd2,
        e_op_itlb_fill_response = 3'd3,
        e_op_itlb_fence         = 3'd4,
        e_op_state_reset        = 3'd5
    } bp_fe_command_queue_opcodes_e;

    localparam int fe_cmd_opcode_width_gp = 3;

endpackage

`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small flop-based FIFO with valid/yumi read side. Head data is visible the
// cycle after it is written into an empty FIFO. Full status is registered and
// asserts one entry early so that an event already past issue still fits.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 70,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    input  logic               yumi_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               full_o
);
    localparam int ptr_w_lp   = $clog2(els_p);
    localparam int count_w_lp = ptr_w_lp + 1;

    logic [width_p-1:0]    mem_q [els_p];
    logic [ptr_w_lp-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [count_w_lp-1:0] count_q, count_d;
    logic                  full_q, full_d;
    logic                  enq, deq;

    // Pointer/count next state; a pop frees a slot for a same-cycle push even when full
    always_comb begin
        deq     = yumi_i & (count_q != '0);
        ready_o = (count_q != count_w_lp'(els_p)) | deq;
        enq     = v_i & ready_o;
        rptr_d  = rptr_q + ptr_w_lp'(deq);
        wptr_d  = wptr_q + ptr_w_lp'(enq);
        count_d = count_q + count_w_lp'(enq) - count_w_lp'(deq);
        full_d  = (count_d >= count_w_lp'(els_p - 1));
    end

    // Control state with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Storage write; contents need no reset since validity lives in count_q
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign v_o    = (count_q != '0);
    assign data_o = mem_q[rptr_q];
    assign full_o = full_q;

endmodule

// File: rtl/bp_be_fe_cmd_gen.sv
// Encodes commit-stage events into FE commands, queues them toward the front
// end and tracks whether an I$ fence is outstanding.
module bp_be_fe_cmd_gen
    import bp_common_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int ptag_width_p  = 28,
    parameter int fe_cmd_els_p  = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  commit_v_i,
    input  logic [vaddr_width_p-1:0]              commit_npc_i,
    input  logic [vaddr_width_p-1:0]              commit_vaddr_i,
    input  logic [ptag_width_p-1:0]               commit_ptag_i,
    input  logic                                  commit_itlb_fill_i,
    input  logic                                  commit_icache_miss_i,
    input  logic                                  commit_fencei_i,
    input  logic                                  commit_sfence_i,
    input  logic                                  commit_satp_i,
    input  logic                                  commit_resume_i,
    output logic [3+vaddr_width_p+ptag_width_p-1:0] fe_cmd_o,
    output logic                                  fe_cmd_v_o,
    input  logic                                  fe_cmd_yumi_i,
    input  logic                                  fe_fence_done_i,
    output logic                                  cmd_full_o,
    output logic                                  fence_busy_o,
    output logic                                  overflow_o
);
    `DECLARE_BP_BE_FE_CMD_S(vaddr_width_p, ptag_width_p);
    localparam int cmd_width_lp = $bits(bp_be_fe_cmd_s);

    typedef enum logic {e_ready, e_fence} state_e;

    bp_be_fe_cmd_s           cmd;
    logic                    cmd_v;
    logic                    fifo_ready, fifo_v;
    logic [cmd_width_lp-1:0] fifo_data;
    logic                    accept, drop, fence_enq;
    state_e                  state_q, state_d;
    logic                    overflow_q, overflow_d;

    // Fixed-priority selection of a single command per commit
    always_comb begin
        cmd   = '0;
        cmd_v = 1'b0;
        if (commit_v_i) begin
            cmd_v = 1'b1;
            if (commit_itlb_fill_i) begin
                cmd.opcode = e_op_itlb_fill_response;
                cmd.vaddr  = commit_vaddr_i;
                cmd.ptag   = commit_ptag_i;
            end else if (commit_icache_miss_i) begin
                cmd.opcode = e_op_icache_fill_resume;
                cmd.vaddr  = commit_vaddr_i;
            end else if (commit_fencei_i) begin
                cmd.opcode = e_op_icache_fence;
                cmd.vaddr  = commit_npc_i;
            end else if (commit_sfence_i) begin
                cmd.opcode = e_op_itlb_fence;
                cmd.vaddr  = commit_npc_i;
            end else if (commit_satp_i) begin
                cmd.opcode = e_op_state_reset;
                cmd.vaddr  = commit_npc_i;
            end else if (commit_resume_i) begin
                cmd.opcode = e_op_pc_redirect;
                cmd.vaddr  = commit_npc_i;
            end else begin
                cmd_v = 1'b0;
            end
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p(cmd_width_lp),
        .els_p  (fe_cmd_els_p)
    ) fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (cmd_v),
        .data_i (cmd),
        .ready_o(fifo_ready),
        .yumi_i (fe_cmd_yumi_i),
        .v_o    (fifo_v),
        .data_o (fifo_data),
        .full_o (cmd_full_o)
    );

    // Fence tracking and sticky overflow; only accepted fences arm the FSM
    always_comb begin
        accept     = cmd_v & fifo_ready;
        drop       = cmd_v & ~fifo_ready;
        fence_enq  = accept & (cmd.opcode == e_op_icache_fence);
        overflow_d = overflow_q | drop;
        state_d    = state_q;
        case (state_q)
            e_ready: if (fence_enq) state_d = e_fence;
            e_fence: if (!fence_enq && fe_fence_done_i) state_d = e_ready;
            default: state_d = e_ready;
        endcase
    end

    // FSM and overflow registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_ready;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    // Protocol checks; a drop is recoverable via overflow_o so it only warns
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(fe_cmd_yumi_i && !fifo_v))
                else $error("fe_cmd yumi asserted with no valid head");
            assert (!drop)
                else $warning("fe_cmd queue overflow: commit event dropped");
        end
    end

    assign fe_cmd_v_o   = fifo_v;
    assign fe_cmd_o     = fifo_v ? fifo_data : '0;
    assign fence_busy_o = (state_q == e_fence);
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// Directed and randomized checks of the FE command generator against a
// queue-based reference model.
module tb_bp_be_fe_cmd_gen;
    localparam int VW = 39;
    localparam int PW = 28;
    localparam int CW = 3 + VW + PW;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          commit_v_i;
    logic [VW-1:0] commit_npc_i, commit_vaddr_i;
    logic [PW-1:0] commit_ptag_i;
    logic          commit_itlb_fill_i, commit_icache_miss_i, commit_fencei_i;
    logic          commit_sfence_i, commit_satp_i, commit_resume_i;
    logic [CW-1:0] fe_cmd_o;
    logic          fe_cmd_v_o, fe_cmd_yumi_i, fe_fence_done_i;
    logic          cmd_full_o, fence_busy_o, overflow_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [CW-1:0] mq[$];
    bit            m_fence;
    bit            m_ovf;

    bp_be_fe_cmd_gen #(.vaddr_width_p(VW), .ptag_width_p(PW), .fe_cmd_els_p(4)) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .commit_v_i          (commit_v_i),
        .commit_npc_i        (commit_npc_i),
        .commit_vaddr_i      (commit_vaddr_i),
        .commit_ptag_i       (commit_ptag_i),
        .commit_itlb_fill_i  (commit_itlb_fill_i),
        .commit_icache_miss_i(commit_icache_miss_i),
        .commit_fencei_i     (commit_fencei_i),
        .commit_sfence_i     (commit_sfence_i),
        .commit_satp_i       (commit_satp_i),
        .commit_resume_i     (commit_resume_i),
        .fe_cmd_o            (fe_cmd_o),
        .fe_cmd_v_o          (fe_cmd_v_o),
        .fe_cmd_yumi_i       (fe_cmd_yumi_i),
        .fe_fence_done_i     (fe_fence_done_i),
        .cmd_full_o          (cmd_full_o),
        .fence_busy_o        (fence_busy_o),
        .overflow_o          (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
    endtask

    function automatic logic [CW-1:0] mk(input int op, input logic [VW-1:0] va, input logic [PW-1:0] pt);
        logic [2:0] o;
        o = 3'(op);
        return {o, va, pt};
    endfunction

    task automatic clear_in();
        reset_i = 1'b0; commit_v_i = 1'b0;
        commit_itlb_fill_i = 1'b0; commit_icache_miss_i = 1'b0; commit_fencei_i = 1'b0;
        commit_sfence_i = 1'b0; commit_satp_i = 1'b0; commit_resume_i = 1'b0;
        fe_cmd_yumi_i = 1'b0; fe_fence_done_i = 1'b0;
    endtask

    // Reference: the queue is the FIFO, the head is mq[0]
    task automatic model_step();
        bit            has_ev, deq, fence_in;
        logic [CW-1:0] ev;
        if (reset_i) begin
            mq.delete(); m_fence = 0; m_ovf = 0;
            $display("reset");
            return;
        end
        has_ev = 1; fence_in = 0; ev = '0;
        if (!commit_v_i)                 has_ev = 0;
        else if (commit_itlb_fill_i)     ev = mk(3, commit_vaddr_i, commit_ptag_i);
        else if (commit_icache_miss_i)   ev = mk(1, commit_vaddr_i, '0);
        else if (commit_fencei_i) begin  ev = mk(2, commit_npc_i, '0); fence_in = 1; end
        else if (commit_sfence_i)        ev = mk(4, commit_npc_i, '0);
        else if (commit_satp_i)          ev = mk(5, commit_npc_i, '0);
        else if (commit_resume_i)        ev = mk(0, commit_npc_i, '0);
        else                             has_ev = 0;
        deq = fe_cmd_yumi_i && (mq.size() > 0);
        if (deq) begin
            $display("pop  cmd=%h", mq[0]);
            void'(mq.pop_front());
        end
        if (has_ev) begin
            if (mq.size() >= 4) begin
                m_ovf = 1; fence_in = 0;
                $display("drop cmd=%h", ev);
            end else begin
                mq.push_back(ev);
                $display("push cmd=%h", ev);
            end
        end
        if (fence_in)                      m_fence = 1;
        else if (m_fence && fe_fence_done_i) m_fence = 0;
    endtask

    task automatic compare_all();
        chk("valid", CW'(fe_cmd_v_o), CW'(mq.size() > 0));
        chk("cmd", fe_cmd_o, (mq.size() > 0) ? mq[0] : '0);
        chk("full", CW'(cmd_full_o), CW'(mq.size() >= 3));
        chk("busy", CW'(fence_busy_o), CW'(m_fence));
        chk("ovf", CW'(overflow_o), CW'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        clear_in();
    endtask

    task automatic commit_resume(input logic [VW-1:0] npc);
        commit_v_i = 1'b1; commit_resume_i = 1'b1; commit_npc_i = npc;
    endtask

    initial begin
        clear_in();
        commit_npc_i = '0; commit_vaddr_i = '0; commit_ptag_i = '0;
        mq.delete(); m_fence = 0; m_ovf = 0;

        // reset state
        reset_i = 1'b1; tick();
        reset_i = 1'b1; tick();
        chk("rst_v", CW'(fe_cmd_v_o), '0);
        chk("rst_ovf", CW'(overflow_o), '0);

        // single resume, then yumi
        commit_resume(39'h80000040); tick();
        chk("resume_cmd", fe_cmd_o, mk(0, 39'h80000040, '0));
        fe_cmd_yumi_i = 1'b1; tick();
        chk("resume_popped", CW'(fe_cmd_v_o), '0);

        // itlb fill wins over resume
        commit_v_i = 1; commit_itlb_fill_i = 1; commit_resume_i = 1;
        commit_vaddr_i = 39'h1000; commit_ptag_i = 28'hABCDE; commit_npc_i = 39'h5555;
        tick();
        chk("itlb_cmd", fe_cmd_o, mk(3, 39'h1000, 28'hABCDE));
        fe_cmd_yumi_i = 1'b1; tick();
        chk("itlb_single", CW'(fe_cmd_v_o), '0);

        // fill to full, overflow on 5th
        for (int i = 0; i < 3; i++) begin commit_resume(39'h100 + 39'(i)); tick(); end
        chk("full_at_3", CW'(cmd_full_o), CW'(1));
        commit_v_i = 1; commit_satp_i = 1; commit_npc_i = 39'h200; tick();
        commit_v_i = 1; commit_sfence_i = 1; commit_npc_i = 39'h300; tick();
        chk("ovf_set", CW'(overflow_o), CW'(1));
        for (int i = 0; i < 4; i++) begin fe_cmd_yumi_i = 1'b1; tick(); end
        chk("drained", CW'(fe_cmd_v_o), '0);

        // full FIFO with simultaneous commit and yumi
        reset_i = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            commit_v_i = 1; commit_icache_miss_i = 1; commit_vaddr_i = 39'h400 + 39'(i); tick();
        end
        commit_resume(39'h777); fe_cmd_yumi_i = 1'b1; tick();
        chk("same_cycle_no_ovf", CW'(overflow_o), '0);
        for (int i = 0; i < 4; i++) begin fe_cmd_yumi_i = 1'b1; tick(); end

        // fence sequence
        commit_v_i = 1; commit_fencei_i = 1; commit_sfence_i = 1; commit_npc_i = 39'h900; tick();
        chk("fence_cmd", fe_cmd_o, mk(2, 39'h900, '0));
        chk("fence_busy", CW'(fence_busy_o), CW'(1));
        commit_v_i = 1; commit_sfence_i = 1; commit_npc_i = 39'h904; tick();
        fe_fence_done_i = 1'b1; tick();
        chk("fence_done", CW'(fence_busy_o), '0);
        for (int i = 0; i < 2; i++) begin fe_cmd_yumi_i = 1'b1; tick(); end

        // reset with entries queued and fence pending
        commit_resume(39'hA00); tick();
        commit_v_i = 1; commit_fencei_i = 1; commit_npc_i = 39'hA04; tick();
        reset_i = 1'b1; tick();
        chk("rst2_v", CW'(fe_cmd_v_o), '0);
        chk("rst2_busy", CW'(fence_busy_o), '0);
        chk("rst2_full", CW'(cmd_full_o), '0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            commit_v_i           = ($urandom_range(0, 9) < 6);
            commit_itlb_fill_i   = ($urandom_range(0, 5) == 0);
            commit_icache_miss_i = ($urandom_range(0, 5) == 0);
            commit_fencei_i      = ($urandom_range(0, 5) == 0);
            commit_sfence_i      = ($urandom_range(0, 5) == 0);
            commit_satp_i        = ($urandom_range(0, 5) == 0);
            commit_resume_i      = ($urandom_range(0, 3) == 0);
            commit_npc_i         = {7'($urandom), $urandom};
            commit_vaddr_i       = {7'($urandom), $urandom};
            commit_ptag_i        = 28'($urandom);
            fe_cmd_yumi_i        = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            fe_fence_done_i      = ($urandom_range(0, 3) == 0);
            reset_i              = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_be_fe_cmd_gen.md
Name: bp_be_fe_cmd_gen

Overview:
Back-end commit-side generator of front-end commands.
- Consumes per-cycle commit events from the CSR/commit stage: redirects, I-TLB fills, I$ fill resumes, fences and SATP writes.
- Encodes each commit event as one FE command and buffers it in a small FIFO toward the front end, using a valid/yumi handshake.
- Provides backpressure and fence-busy status to issue logic.

Parameters:
vaddr_width_p, 39, virtual address width.
ptag_width_p, 28, physical tag width.
fe_cmd_els_p, 4, FE command FIFO depth (power of 2, >=2).

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
commit_v_i  in  1  commit event valid this cycle
commit_npc_i  in  vaddr_width_p  next PC after commit
commit_vaddr_i  in  vaddr_width_p  faulting/fill vaddr
commit_ptag_i  in  ptag_width_p  I-TLB fill ptag
commit_itlb_fill_i  in  1  I-TLB fill response
commit_icache_miss_i  in  1  I$ fill resume
commit_fencei_i  in  1  fence.i committed
commit_sfence_i  in  1  sfence.vma committed
commit_satp_i  in  1  SATP/priv change, state reset
commit_resume_i  in  1  plain PC redirect (trap/xret/mispredict)
fe_cmd_o  out  3+vaddr_width_p+ptag_width_p  {opcode, vaddr, ptag}
fe_cmd_v_o  out  1  FIFO head valid
fe_cmd_yumi_i  in  1  FE consumed head (only when fe_cmd_v_o)
fe_fence_done_i  in  1  FE finished I$ fence
cmd_full_o  out  1  issue must stall
fence_busy_o  out  1  waiting for fence completion
overflow_o  out  1  sticky: event dropped while FIFO full

Behaviour:
- Reset values: fe_cmd_v_o=0, cmd_full_o=0, fence_busy_o=0, overflow_o=0. fe_cmd_o is don't-care when invalid; drive 0.
- Reset at any time empties the FIFO, returns the FSM to e_ready and clears overflow_o. A command in flight is discarded.
- Opcodes (3b): 0 pc_redirect, 1 icache_fill_resume, 2 icache_fence, 3 itlb_fill_response, 4 itlb_fence, 5 state_reset.
- One command per commit, selected by fixed priority: itlb_fill > icache_miss > fencei > sfence > satp > resume. Lower-priority flags in the same cycle are ignored.
- Commit with no flags set enqueues nothing.
- Command vaddr field:
  - itlb_fill and icache_miss use commit_vaddr_i.
  - All other opcodes use commit_npc_i.
- ptag field carries commit_ptag_i for itlb_fill and 0 otherwise.
- Latency: an event committed in cycle N appears at the FIFO head in N+1 if the FIFO was empty. Ordering is FIFO.
- Handshake: the head is popped on fe_cmd_yumi_i & fe_cmd_v_o. A yumi while invalid is an error (assertion) and has no effect.
- Simultaneous enqueue and dequeue are allowed at any occupancy, including full: count unchanged, data correct.
- Count: log2(fe_cmd_els_p)+1 bits, 0..fe_cmd_els_p. Pointers wrap modulo depth.
- cmd_full_o = (count >= fe_cmd_els_p-1), registered from next-state count. This reserves one slot for an event already past issue.
- Enqueue while count == fe_cmd_els_p and no same-cycle dequeue: the event is dropped, overflow_o is set (sticky until reset) and an assertion fires.
- FSM:
  - e_ready -> e_fence when an icache_fence command is enqueued.
  - e_fence -> e_ready on fe_fence_done_i.
  - fence_busy_o = (state == e_fence).
  - fe_fence_done_i in e_ready is ignored.
  - A new fencei enqueued in e_fence in the same cycle as done keeps the FSM in e_fence.
  - Other commits in e_fence are enqueued normally. Issue stalling is the consumer's job.
  - A dropped fencei (overflow) does not enter e_fence.

Decomposition:
- bp_common_pkg holds the FE command opcode enum (bp_fe_command_queue_opcodes_e extension) and a packed bp_be_fe_cmd_s struct macro parameterized by vaddr/ptag widths.
- The FSM state enum stays local.
- One natural sub-module: bsg_fifo_1r1w_small storing bp_be_fe_cmd_s. Count and full logic live in this block.

Test Plan:
- Single resume commit, npc=0x80000040, FIFO empty -> next cycle fe_cmd_v_o=1, opcode 0, vaddr 0x80000040, ptag 0. Yumi -> fe_cmd_v_o=0.
- itlb_fill with vaddr=0x1000, ptag=0xABCDE, plus resume set the same cycle -> exactly one command: opcode 3, vaddr 0x1000, ptag 0xABCDE.
- Depth 4, no yumi, 3 commits -> cmd_full_o=1 after the 3rd. 4th commit accepted. 5th dropped and overflow_o=1. Drain 4 in order: opcodes/values match.
- Full FIFO with commit and yumi in the same cycle -> count stays 4, no overflow, new entry appears last.
- fencei commit -> opcode 2 enqueued, fence_busy_o=1 the following cycle. sfence committed during the fence is still enqueued. fe_fence_done_i -> fence_busy_o=0 next cycle.
- Reset asserted with 2 entries queued and state e_fence -> next cycle fe_cmd_v_o=0, fence_busy_o=0, cmd_full_o=0, overflow_o=0.
